// File: rtl/div_pkg.sv
// Shared constants for the sequential divider: FSM encoding and register-file tag width.
package div_pkg;

  localparam int unsigned TAGW = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] p,
  input  logic             dmsb,
  input  logic [WIDTH-1:0] bq,
  output logic [WIDTH-1:0] p_nxt_c,
  output logic             qbit_c
);

  logic [WIDTH:0]   t;
  logic [WIDTH+1:0] sum;

  assign t = {p, dmsb};

  // Subtract as add of inverted divisor with carry-in; carry-out means t >= divisor.
  assign sum = {1'b0, t} + {1'b0, ~{1'b0, bq}} + (WIDTH+2)'(1);

  assign qbit_c = sum[WIDTH+1];

  // The kept remainder is always below the divisor, so its top bit is zero.
  assign p_nxt_c = qbit_c ? WIDTH'(sum[WIDTH:0]) : WIDTH'(t);

endmodule

// File: rtl/div_seq.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake and a writeback tag.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  input  logic [TAGW-1:0]  Rdin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic [TAGW-1:0]  Rdout,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] bq;
  logic [CW-1:0]    cnt;
  logic [TAGW-1:0]  tag;
  logic [WIDTH-1:0] p_nxt_c;
  logic             qbit_c;
  logic             accept_c;
  logic             last_c;

  assign accept_c = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_c   = (state == S_RUN) && (cnt == CW'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .p       (p),
    .dmsb    (d[WIDTH-1]),
    .bq      (bq),
    .p_nxt_c (p_nxt_c),
    .qbit_c  (qbit_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; DONE accepts a new request exactly like IDLE
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = (b == '0) ? S_DONE : S_RUN;
        else       state_nxt = S_IDLE;
      end
      S_RUN:   state_nxt = last_c ? S_DONE : S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p   <= '0;
      d   <= '0;
      bq  <= '0;
      cnt <= '0;
      tag <= '0;
    end else if (accept_c) begin
      p   <= '0;
      d   <= a;
      bq  <= b;
      cnt <= '0;
      tag <= Rdin;
    end else if (state == S_RUN) begin
      p   <= p_nxt_c;
      d   <= {d[WIDTH-2:0], qbit_c};
      cnt <= cnt + CW'(1);
    end
  end

  // Result registers hold until the next completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      q     <= '0;
      r     <= '0;
      Rdout <= '0;
    end else begin
      busy <= (state_nxt == S_RUN);
      done <= (state_nxt == S_DONE);
      if (accept_c && (b == '0)) begin
        q     <= '1;
        r     <= a;
        Rdout <= Rdin;
        dbz   <= 1'b1;
      end else if (last_c) begin
        q     <= {d[WIDTH-2:0], qbit_c};
        r     <= p_nxt_c;
        Rdout <= tag;
        dbz   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle unsigned restoring divider: the inverse counterpart to the pipelined multiplier in the execute stage.
- Accepts dividend, divisor and a 5-bit destination-register tag, then produces quotient, remainder and the same tag for writeback into the register file.
- Computes one quotient bit per clock and is non-pipelined: it holds one operation at a time.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand width in bits; must be at least 2.
- CW, $clog2(WIDTH)+1, iteration-counter width (localparam).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- a  input  WIDTH  dividend, unsigned.
- b  input  WIDTH  divisor, unsigned.
- start  input  1  request; sampled on the rising clk edge.
- Rdin  input  5  destination-register tag for this operation.
- q  output  WIDTH  quotient, registered.
- r  output  WIDTH  remainder, registered.
- Rdout  output  5  tag of the result currently on q/r.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: q/r/Rdout are newly valid.
- dbz  output  1  divide-by-zero flag, qualified by done.

Behaviour:
- Reset (rst low, asynchronous, independent of clk):
  - state=IDLE.
  - q, r, Rdout, busy, done, dbz and all internal registers = 0.
  - A reset during RUN aborts the operation; no done is issued.
- States:
  - IDLE: busy=0, done=0. On start=1 at an edge:
    - capture a, b and Rdin into internal regs;
    - partial remainder P=0, shift register D=a, cnt=0;
    - if b!=0, go to RUN; if b==0, go to DONE with the divide-by-zero result.
  - RUN: busy=1. Each edge performs one restoring step:
    - T = {P[WIDTH-1:0], D[WIDTH-1]} (WIDTH+1 bits);
    - if T >= {1'b0, bq}: P = T - bq, shift 1 into D's LSB; else P = T, shift 0 in;
    - cnt++.
    - On the edge where cnt reaches WIDTH-1, i.e. the WIDTH-th step, go to DONE and load q=quotient, r=remainder, Rdout=captured tag, dbz=0.
  - DONE: done=1, busy=0; lasts exactly one cycle.
    - start=1 at the next edge is accepted exactly as in IDLE (back-to-back issue).
    - Otherwise go to IDLE.
- Latency: start accepted at edge k → done high during the cycle after edge k+WIDTH. For WIDTH=16, done is seen after the 16th edge following acceptance. Issue interval is WIDTH+1 cycles.
- Divide by zero: b==0 at acceptance → DONE after edge k with q = all ones, r = a, Rdout = Rdin, dbz = 1. Latency is 1.
- start while busy=1 is ignored; a, b and Rdin changes during RUN have no effect.
- q, r, Rdout and dbz hold their values after done until the next completion or reset.
- The tag is carried with its own operation only; Rdout never changes except when done is asserted.
- Arithmetic:
  - the partial remainder is WIDTH+1 bits internally;
  - the result is always exact: q*b + r == a and r < b;
  - no signed mode.
- The next cannot be DONE and IDLE at once.

Decomposition:
- Shared package div_pkg:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - TAGW=5 (register-file index width, shared with the multiplier pipe and rfile).
- Sub-module div_step (combinational):
  - inputs P, D MSB, divisor;
  - outputs next P and quotient bit;
  - parameterised by WIDTH, built on the existing yAdder for the subtract (b inverted, cin=1).
- The FSM, counter and output registers live in div_seq.

Test Plan:
- WIDTH=16; a=100, b=7, Rdin=3, start pulse → after 16 edges done=1 for 1 cycle, q=14, r=2, Rdout=3, dbz=0; busy=1 throughout the 16 RUN cycles.
- a=16'hFFFF, b=1, Rdin=31 → q=16'hFFFF, r=0, Rdout=31. Then a=3, b=10 → q=0, r=3. Then a=16'hFFFF, b=16'hFFFF → q=1, r=0.
- a=5, b=0, Rdin=9 → done on the cycle after the accepting edge, dbz=1, q=16'hFFFF, r=5, Rdout=9; busy never asserts.
- Accept a=50, b=5, Rdin=1; hold start=1 with a=77, b=7, Rdin=2 during RUN → first result q=10, r=0, Rdout=1. The request still held in DONE is accepted; 17 cycles later q=11, r=0, Rdout=2.
- Accept a=1000, b=3; drop rst low after 5 RUN edges → immediately q=r=Rdout=0, busy=done=dbz=0, no done pulse. After release, a new 1000/3 → q=333, r=1.
- Random regression: 200 random a/b (including b=0) with tags i%32 → every done matches q=a/b and r=a%b (b!=0), Rdout matches the tag, and exactly one done per accepted start.
